// File: rtl/prog_timer_pkg.sv
// Shared types and default widths for the programmable down-counting timer.
package prog_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic {
      ONE_SHOT = 1'b0,
      PERIODIC = 1'b1
   } mode_t;

   localparam int DEF_CNT_W   = 32;
   localparam int DEF_PRESC_W = 8;
   localparam int DEF_EXP_W   = 8;

endpackage

// File: rtl/prog_timer_tick_gen.sv
// Prescaler: wraps 0..presc while enabled and flags the wrap cycle as a tick.
module tick_gen
   import prog_timer_pkg::*;
#(
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt;

   assign tick = en && (cnt == presc);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/prog_timer.sv
// Programmable down-counting timer: one-shot/periodic, prescaled, with hold, abort and expiry count.
module prog_timer
   import prog_timer_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PRESC_W = DEF_PRESC_W,
   parameter int EXP_W   = DEF_EXP_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               hold,
   input  logic               periodic,
   input  logic [CNT_W-1:0]   load_val,
   input  logic [PRESC_W-1:0] presc,
   output logic               ready,
   output logic               busy,
   output logic               notify,
   output logic               err,
   output logic [CNT_W-1:0]   count,
   output logic [EXP_W-1:0]   exp_cnt
);

   state_t             state;
   mode_t              mode_q;
   logic [CNT_W-1:0]   count_q;
   logic [CNT_W-1:0]   load_q;
   logic [PRESC_W-1:0] presc_q;
   logic [EXP_W-1:0]   exp_q;
   logic               notify_q;
   logic               err_q;

   logic active;
   logic start_ok;
   logic tick;

   function automatic logic [EXP_W-1:0] sat_inc(input logic [EXP_W-1:0] v);
      return (&v) ? v : v + EXP_W'(1);
   endfunction

   assign active   = (state != IDLE);
   assign start_ok = !stop && start && (load_val != '0);

   // The prescaler only advances on cycles where nothing outranks the tick.
   tick_gen #(
      .PRESC_W (PRESC_W)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (stop || start_ok),
      .en    (active && !hold && !stop && !start_ok),
      .presc (presc_q),
      .tick  (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         mode_q   <= ONE_SHOT;
         count_q  <= '0;
         load_q   <= '0;
         presc_q  <= '0;
         exp_q    <= '0;
         notify_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         notify_q <= 1'b0;
         err_q    <= 1'b0;
         if (stop) begin
            if (active) begin
               state   <= IDLE;
               count_q <= '0;
            end
         end else if (start_ok) begin
            load_q  <= load_val;
            presc_q <= presc;
            mode_q  <= periodic ? PERIODIC : ONE_SHOT;
            count_q <= load_val;
            exp_q   <= '0;
            state   <= hold ? HOLD : RUN;
         end else begin
            // A rejected start only flags err; a running timer carries on.
            err_q <= start;
            if (active) begin
               if (hold) begin
                  state <= HOLD;
               end else begin
                  state <= RUN;
                  if (tick) begin
                     if (count_q == CNT_W'(1)) begin
                        notify_q <= 1'b1;
                        exp_q    <= sat_inc(exp_q);
                        if (mode_q == PERIODIC) begin
                           count_q <= load_q;
                        end else begin
                           count_q <= '0;
                           state   <= IDLE;
                        end
                     end else begin
                        count_q <= count_q - CNT_W'(1);
                     end
                  end
               end
            end
         end
      end
   end

   assign ready   = (state == IDLE);
   assign busy    = (state == RUN) || (state == HOLD);
   assign notify  = notify_q;
   assign err     = err_q;
   assign count   = count_q;
   assign exp_cnt = exp_q;

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: vector table, corner-case sequences, random run against a cycle-budget model.
module tb_prog_timer;

   localparam int CNT_W   = 32;
   localparam int PRESC_W = 8;
   localparam int EXP_W   = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic               stop = 1'b0;
   logic               hold = 1'b0;
   logic               periodic = 1'b0;
   logic [CNT_W-1:0]   load_val = '0;
   logic [PRESC_W-1:0] presc = '0;
   logic               ready, busy, notify, err;
   logic [CNT_W-1:0]   count;
   logic [EXP_W-1:0]   exp_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   prog_timer #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W),
      .EXP_W   (EXP_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .stop     (stop),
      .hold     (hold),
      .periodic (periodic),
      .load_val (load_val),
      .presc    (presc),
      .ready    (ready),
      .busy     (busy),
      .notify   (notify),
      .err      (err),
      .count    (count),
      .exp_cnt  (exp_cnt)
   );

   typedef struct {
      logic [3:0]       ctl;   // start, stop, hold, periodic
      logic [CNT_W-1:0] ld;
      logic [PRESC_W-1:0] ps;
      logic [3:0]       flg;   // ready, busy, notify, err
      logic [CNT_W-1:0] cnt;
      logic [EXP_W-1:0] ex;
   } vec_t;

   vec_t vt[16];

   // Cycle-budget model: remaining active cycles until expiry.
   bit              m_act;
   bit              m_per_mode;
   longint unsigned m_rem, m_period, m_div;
   int              m_exps;
   bit              m_notify, m_err;

   function automatic vec_t mk(input logic [3:0] ctl, input int ld, input int ps,
                               input logic [3:0] flg, input int cnt, input int ex);
      vec_t v;
      v.ctl = ctl;
      v.ld  = CNT_W'(ld);
      v.ps  = PRESC_W'(ps);
      v.flg = flg;
      v.cnt = CNT_W'(cnt);
      v.ex  = EXP_W'(ex);
      return v;
   endfunction

   function automatic logic [63:0] outs();
      return {20'd0, ready, busy, notify, err, count, exp_cnt};
   endfunction

   function automatic logic [63:0] pack(input logic [3:0] flg, input logic [CNT_W-1:0] cnt,
                                        input logic [EXP_W-1:0] ex);
      return {20'd0, flg, cnt, ex};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      start = 1'b0;
      stop  = 1'b0;
      hold  = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic do_start(input longint unsigned l, input int p, input int per);
      start    = 1'b1;
      load_val = CNT_W'(l);
      presc    = PRESC_W'(p);
      periodic = (per != 0);
      step();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic model_reset();
      m_act = 0; m_per_mode = 0; m_rem = 0; m_period = 0; m_div = 1;
      m_exps = 0; m_notify = 0; m_err = 0;
   endtask

   task automatic model_edge();
      m_notify = 0;
      m_err    = 0;
      if (stop) begin
         if (m_act) begin
            m_act = 0;
            m_rem = 0;
         end
      end else if (start && load_val != '0) begin
         m_act      = 1;
         m_div      = longint'(presc) + 1;
         m_period   = longint'(load_val) * m_div;
         m_rem      = m_period;
         m_per_mode = periodic;
         m_exps     = 0;
      end else begin
         m_err = start;
         if (m_act && !hold) begin
            m_rem--;
            if (m_rem == 0) begin
               m_notify = 1;
               if (m_exps < 255) m_exps++;
               if (m_per_mode) m_rem = m_period;
               else m_act = 0;
            end
         end
      end
   endtask

   function automatic logic [63:0] model_outs();
      longint unsigned c;
      c = m_act ? (m_rem + m_div - 1) / m_div : 0;
      return pack({!m_act, m_act, m_notify, m_err}, CNT_W'(c), EXP_W'(m_exps));
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int pulses;
      int first;
      bit ok;

      do_reset();
      chk("reset_state", outs(), pack(4'b1000, 0, 0));

      vt[0]  = mk(4'b1000, 3, 0, 4'b0100, 3, 0);
      vt[1]  = mk(4'b0000, 0, 0, 4'b0100, 2, 0);
      vt[2]  = mk(4'b0000, 0, 0, 4'b0100, 1, 0);
      vt[3]  = mk(4'b0000, 0, 0, 4'b1010, 0, 1);
      vt[4]  = mk(4'b0000, 0, 0, 4'b1000, 0, 1);
      vt[5]  = mk(4'b1000, 0, 0, 4'b1001, 0, 1);
      vt[6]  = mk(4'b0000, 0, 0, 4'b1000, 0, 1);
      vt[7]  = mk(4'b1001, 2, 1, 4'b0100, 2, 0);
      vt[8]  = mk(4'b0000, 0, 0, 4'b0100, 2, 0);
      vt[9]  = mk(4'b0000, 0, 0, 4'b0100, 1, 0);
      vt[10] = mk(4'b0000, 0, 0, 4'b0100, 1, 0);
      vt[11] = mk(4'b0000, 0, 0, 4'b0110, 2, 1);
      vt[12] = mk(4'b0000, 0, 0, 4'b0100, 2, 1);
      vt[13] = mk(4'b1000, 0, 0, 4'b0101, 1, 1);
      vt[14] = mk(4'b0100, 0, 0, 4'b1000, 0, 1);
      vt[15] = mk(4'b0100, 0, 0, 4'b1000, 0, 1);

      for (int i = 0; i < 16; i++) begin
         start    = vt[i].ctl[3];
         stop     = vt[i].ctl[2];
         hold     = vt[i].ctl[1];
         periodic = vt[i].ctl[0];
         load_val = vt[i].ld;
         presc    = vt[i].ps;
         step();
         chk($sformatf("vec%0d", i), outs(), pack(vt[i].flg, vt[i].cnt, vt[i].ex));
      end
      idle_in();

      // Periodic with prescaler: load 2, presc 4 gives a 10-cycle period.
      do_start(2, 4, 1);
      pulses = 0; first = -1; ok = 1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (notify) begin
            pulses++;
            if (first < 0) first = c;
         end
         if (!busy || ready) ok = 0;
      end
      chk("per_pulses", pulses, 4);
      chk("per_first", first, 10);
      chk("per_exp_cnt", exp_cnt, 4);
      chk("per_busy", ok, 1);
      do_stop();
      chk("stop_keeps_exp", outs(), pack(4'b1000, 0, 4));

      // Hold for 7 cycles after two ticks delays expiry by 7.
      do_start(5, 0, 0);
      step(); step();
      chk("hold_pre", count, 3);
      hold = 1'b1; ok = 1;
      repeat (7) begin
         step();
         if (count != 3 || !busy) ok = 0;
      end
      hold = 1'b0;
      chk("hold_frozen", ok, 1);
      k = 9;
      while (k < 30) begin
         step();
         k++;
         if (notify) break;
      end
      chk("hold_latency", k, 12);
      chk("hold_done", outs(), pack(4'b1010, 0, 1));

      // Abort at count 2: no notify afterwards.
      do_start(5, 0, 0);
      step(); step(); step();
      chk("abort_pre", count, 2);
      do_stop();
      chk("abort_state", outs(), pack(4'b1000, 0, 0));
      pulses = 0;
      repeat (10) begin
         step();
         if (notify) pulses++;
      end
      chk("abort_no_notify", pulses, 0);

      // Restart on the exact expiry cycle.
      do_start(3, 0, 0);
      step(); step();
      chk("restart_pre", count, 1);
      do_start(4, 0, 0);
      chk("restart_on_exp", outs(), pack(4'b0100, 4, 0));
      do_stop();

      // Stop on the expiry tick.
      do_start(2, 0, 0);
      step();
      do_stop();
      chk("stop_on_exp", outs(), pack(4'b1000, 0, 0));

      // Hold on the expiry tick: freeze at 1, expire after release.
      do_start(2, 0, 0);
      step();
      hold = 1'b1;
      repeat (3) step();
      chk("hold_on_exp", outs(), pack(4'b0100, 1, 0));
      hold = 1'b0;
      step();
      chk("hold_exp_release", outs(), pack(4'b1010, 0, 1));

      // Saturating expiry counter.
      do_start(1, 0, 1);
      repeat (300) step();
      chk("sat_exp", outs(), pack(4'b0110, 1, 255));
      do_stop();

      // Largest load value.
      do_start(64'hFFFF_FFFF, 0, 0);
      chk("max_load", count, 64'hFFFF_FFFF);
      step();
      chk("max_load_dec", count, 64'hFFFF_FFFE);
      do_stop();

      // Synchronous reset: no effect until the edge.
      do_start(4, 0, 0);
      step(); step();
      chk("rst_pre", outs(), pack(4'b0100, 2, 0));
      rst_n = 1'b0;
      #2;
      chk("rst_no_edge", outs(), pack(4'b0100, 2, 0));
      step();
      chk("rst_edge", outs(), pack(4'b1000, 0, 0));
      rst_n = 1'b1;
      pulses = 0;
      repeat (5) begin
         step();
         if (notify) pulses++;
      end
      chk("rst_no_notify", pulses, 0);

      // Random stimulus against the model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         int r;
         r        = $urandom_range(0, 99);
         start    = (r < 6);
         stop     = (r >= 6 && r < 9);
         hold     = ($urandom_range(0, 9) < 2);
         load_val = CNT_W'($urandom_range(0, 6));
         presc    = PRESC_W'($urandom_range(0, 3));
         periodic = $urandom_range(0, 1) != 0;
         model_edge();
         step();
         chk($sformatf("rand%0d", c), outs(), model_outs());
      end
      idle_in();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
Fully synchronous, programmable down-counting timer. It is the parametrised successor to the fixed 1 s ripple-counter timer.
- Adds a runtime load value, a clock prescaler, one-shot and periodic modes, hold/resume, abort, and an expiry counter.
- Sits beside the lab-3 control FSMs, which use it for second-scale and sub-second event pacing.
- All state is clocked by the single clk.
- There are no derived clocks.

Parameters:
CNT_W, 32, width of load value and remaining-count register
PRESC_W, 8, width of prescaler divisor (tick every presc+1 clk cycles)
EXP_W, 8, width of saturating expiry counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low, sampled on rising clk
start  in  1  pulse: latch load_val/presc/periodic, (re)start timer
stop  in  1  pulse: abort, return to IDLE, no notify
hold  in  1  level: freeze prescaler and count while high
periodic  in  1  mode sampled at start: 1 = auto-reload, 0 = one-shot
load_val  in  CNT_W  ticks until expiry, sampled at start
presc  in  PRESC_W  prescaler divisor, sampled at start
ready  out  1  high in IDLE
busy  out  1  high in RUN or HOLD
notify  out  1  one-cycle pulse at each expiry
err  out  1  one-cycle pulse when start rejected (load_val == 0)
count  out  CNT_W  remaining ticks
exp_cnt  out  EXP_W  expiries since last start, saturating

Behaviour:
- Reset (rst_n == 0 at rising clk):
  - state IDLE, count 0, prescaler 0, exp_cnt 0.
  - ready 1, busy 0, notify 0, err 0.
  - Latched load/presc/mode registers cleared.
  - Reset mid-run aborts with no notify.
- States: IDLE, RUN, HOLD.
- Input priority per cycle: stop > start > hold > tick.
- start with load_val != 0, from any state:
  - Latch load_q, presc_q, mode_q.
  - count <= load_val, prescaler <= 0, exp_cnt <= 0.
  - Go to RUN, or to HOLD if hold is also high.
- start with load_val == 0:
  - err pulses 1 cycle.
  - State and all registers unchanged; a running timer continues.
- stop in RUN or HOLD: go to IDLE, count <= 0, no notify. exp_cnt is preserved. stop in IDLE has no effect.
- RUN with hold == 1: go to HOLD, prescaler and count frozen. HOLD with hold == 0: return to RUN the next cycle and resume from the frozen values.
- Prescaler in RUN: counts 0..presc_q.
  - At presc_q it wraps to 0 and asserts an internal tick for that cycle.
  - presc_q == 0 gives a tick every cycle.
- Tick with count > 1: count <= count - 1.
- Tick with count == 1 (expiry):
  - notify is high for exactly the next cycle.
  - exp_cnt increments, saturating at 2^EXP_W-1.
  - Periodic mode: count <= load_q, stay in RUN; there is no dead cycle between periods.
  - One-shot mode: count <= 0, go to IDLE.
- Latency: start sampled at edge E0 → notify high during the cycle after edge E0 + load_val*(presc+1).
  - Example: load 3, presc 0 → notify visible 3 cycles after the start edge.
  - Period in periodic mode is exactly load_q*(presc_q+1) cycles.
- Simultaneous events:
  - start on the expiry tick restarts with no notify.
  - stop on the expiry tick gives no notify.
  - hold on the expiry tick freezes count at 1; the expiry happens after resume.
- Wrap-around: count never underflows. load_val = 2^CNT_W-1 is legal.
- ready and busy are registered state decodes; they are never both high.

Decomposition:
- Package prog_timer_pkg holds:
  - enum state_t {IDLE, RUN, HOLD}
  - enum mode_t {ONE_SHOT, PERIODIC}
  - localparam default widths
- One sub-module, tick_gen:
  - Parameterised PRESC_W prescaler.
  - Inputs: clk, rst_n, clr, en, presc.
  - Output: tick.
  - The top-level FSM and count datapath stay in prog_timer.

Test Plan:
- One-shot timing: reset; start, load 3, presc 0, periodic 0 → notify single pulse 3 cycles after the start edge; then ready 1, count 0, exp_cnt 1.
- Periodic with prescaler: start, load 2, presc 4 → notify every 10 cycles, 4 pulses in 40 cycles; exp_cnt 4; busy stays 1.
- Hold: load 5, presc 0; hold high for 7 cycles after 2 ticks → count frozen at 3 during HOLD; notify delayed by exactly 7 cycles.
- Abort and restart: stop while count = 2 → no notify, ready 1. Later, start with load 4 on the exact expiry cycle of a running timer → no notify that cycle, count 4, exp_cnt 0.
- Rejection and saturation: start, load 0 → err 1-cycle, state unchanged. Periodic load 1, presc 0, EXP_W 8, run 300 cycles → exp_cnt saturates at 255.
- Synchronous reset: rst_n low mid-run at count 2 → after the next edge all outputs at reset values. rst_n low between edges without an edge → no change.
